// File: rtl/control_loop_scheduler_pkg.sv
// Shared state encodings and default constants for the flight-control loop scheduler.
package control_loop_scheduler_pkg;

  typedef enum logic [2:0] {
    SCHED_WAIT_IMU = 3'd0,
    SCHED_RUN_AC   = 3'd1,
    SCHED_RUN_BF   = 3'd2,
    SCHED_UPDATE   = 3'd3,
    SCHED_FAULT    = 3'd4
  } sched_state_e;

  localparam int unsigned DEF_REC_VAL_BIT_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 38000;     // 1 ms at 38 MHz
  localparam int unsigned DEF_ARM_THROTTLE_MAX  = 10;
  localparam int unsigned DEF_ARM_HOLD_CYCLES   = 38000000;  // 1 s at 38 MHz
  localparam int unsigned STATS_W               = 16;

  // States in which an iteration is in flight and new IMU samples are dropped.
  function automatic logic is_busy(input sched_state_e s);
    return (s == SCHED_RUN_AC) || (s == SCHED_RUN_BF) || (s == SCHED_UPDATE);
  endfunction

endpackage

// File: rtl/control_loop_scheduler_arm_controller.sv
// Arming logic: motors enable only after the IMU is good and throttle has been
// held low for a full hold period; disarms on IMU loss or scheduler fault.
module arm_controller
  import control_loop_scheduler_pkg::*;
#(
  parameter int unsigned REC_VAL_BIT_WIDTH = DEF_REC_VAL_BIT_WIDTH,
  parameter int unsigned ARM_THROTTLE_MAX  = DEF_ARM_THROTTLE_MAX,
  parameter int unsigned ARM_HOLD_CYCLES   = DEF_ARM_HOLD_CYCLES
) (
  input  logic                         sys_clk,
  input  logic                         resetn,
  input  logic                         imu_good,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic                         fault,
  output logic                         motor_enable
);

  localparam int unsigned HW = $clog2(ARM_HOLD_CYCLES + 1);
  localparam logic [HW-1:0]                HOLD_MAX = HW'(ARM_HOLD_CYCLES);
  localparam logic [REC_VAL_BIT_WIDTH-1:0] THR_MAX  = REC_VAL_BIT_WIDTH'(ARM_THROTTLE_MAX);

  logic [HW-1:0] hold_q, hold_d;
  logic          enable_q, enable_d;
  logic          low_c;

  // Hold counter saturates; enable latches once saturated and only drops on IMU loss or fault.
  always_comb begin
    low_c    = imu_good && (throttle_val <= THR_MAX) && !fault;
    hold_d   = '0;
    enable_d = enable_q;
    if (low_c) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
    end
    if (!imu_good || fault) begin
      enable_d = 1'b0;
    end else if (hold_q == HOLD_MAX) begin
      enable_d = 1'b1;
    end
  end

  // Arming state registers.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      hold_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      enable_q <= enable_d;
    end
  end

  assign motor_enable = enable_q;

endmodule

// File: rtl/control_loop_scheduler.sv
// Sequences one control iteration per IMU sample (angle controller, then body
// frame controller, then motor-mixer update), owns arming and stage timeouts.
// Optional build macro OVERRUN_STATS_EN adds overrun_cnt and loop_cnt outputs.
module control_loop_scheduler
  import control_loop_scheduler_pkg::*;
#(
  parameter int unsigned REC_VAL_BIT_WIDTH = DEF_REC_VAL_BIT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ARM_THROTTLE_MAX  = DEF_ARM_THROTTLE_MAX,
  parameter int unsigned ARM_HOLD_CYCLES   = DEF_ARM_HOLD_CYCLES
) (
  input  logic                         sys_clk,
  input  logic                         resetn,
  input  logic                         imu_good,
  input  logic                         imu_valid_strobe,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic                         ac_complete,
  input  logic                         bf_complete,
  output logic                         ac_start,
  output logic                         bf_start,
  output logic                         motor_update,
  output logic                         motor_enable,
  output logic                         fault,
  output logic                         busy
`ifdef OVERRUN_STATS_EN
  ,
  output logic [STATS_W-1:0]           overrun_cnt,
  output logic [STATS_W-1:0]           loop_cnt
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ac_start_q, ac_start_d;
  logic          bf_start_q, bf_start_d;
  logic          motor_update_q, motor_update_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;
  logic          timeout_c;

  // Next-state and registered-output decode; a completion beats a same-cycle timeout.
  always_comb begin
    state_d        = state_q;
    timer_d        = '0;
    ac_start_d     = 1'b0;
    bf_start_d     = 1'b0;
    motor_update_d = 1'b0;
    timeout_c      = (timer_q == TIMER_LAST);
    case (state_q)
      SCHED_WAIT_IMU: begin
        if (imu_valid_strobe && imu_good) begin
          state_d    = SCHED_RUN_AC;
          ac_start_d = 1'b1;
        end
      end
      SCHED_RUN_AC: begin
        if (ac_complete) begin
          state_d    = SCHED_RUN_BF;
          bf_start_d = 1'b1;
        end else if (timeout_c) begin
          state_d = SCHED_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SCHED_RUN_BF: begin
        if (bf_complete) begin
          state_d        = SCHED_UPDATE;
          motor_update_d = 1'b1;
        end else if (timeout_c) begin
          state_d = SCHED_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SCHED_UPDATE: state_d = SCHED_WAIT_IMU;
      SCHED_FAULT:  state_d = SCHED_FAULT;
      default:      state_d = SCHED_WAIT_IMU;
    endcase
    fault_d = (state_d == SCHED_FAULT);
    busy_d  = is_busy(state_d);
  end

  // Sequencer state and output registers.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_q        <= SCHED_WAIT_IMU;
      timer_q        <= '0;
      ac_start_q     <= 1'b0;
      bf_start_q     <= 1'b0;
      motor_update_q <= 1'b0;
      fault_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      ac_start_q     <= ac_start_d;
      bf_start_q     <= bf_start_d;
      motor_update_q <= motor_update_d;
      fault_q        <= fault_d;
      busy_q         <= busy_d;
    end
  end

  // Fault entry is fed from next-state so motors drop in the same cycle fault rises.
  arm_controller #(
    .REC_VAL_BIT_WIDTH (REC_VAL_BIT_WIDTH),
    .ARM_THROTTLE_MAX  (ARM_THROTTLE_MAX),
    .ARM_HOLD_CYCLES   (ARM_HOLD_CYCLES)
  ) u_arm (
    .sys_clk      (sys_clk),
    .resetn       (resetn),
    .imu_good     (imu_good),
    .throttle_val (throttle_val),
    .fault        (fault_d),
    .motor_enable (motor_enable)
  );

  assign ac_start     = ac_start_q;
  assign bf_start     = bf_start_q;
  assign motor_update = motor_update_q;
  assign fault        = fault_q;
  assign busy         = busy_q;

`ifdef OVERRUN_STATS_EN
  logic [STATS_W-1:0] overrun_cnt_q, overrun_cnt_d;
  logic [STATS_W-1:0] loop_cnt_q, loop_cnt_d;

  // Dropped-strobe count saturates; completed-loop count wraps.
  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    loop_cnt_d    = loop_cnt_q;
    if (imu_valid_strobe && busy_q && (overrun_cnt_q != '1)) begin
      overrun_cnt_d = overrun_cnt_q + STATS_W'(1);
    end
    if (motor_update_d) begin
      loop_cnt_d = loop_cnt_q + STATS_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      overrun_cnt_q <= '0;
      loop_cnt_q    <= '0;
    end else begin
      overrun_cnt_q <= overrun_cnt_d;
      loop_cnt_q    <= loop_cnt_d;
    end
  end

  assign overrun_cnt = overrun_cnt_q;
  assign loop_cnt    = loop_cnt_q;
`endif

endmodule
